// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and parity helper.
// Used by the receiver and intended for the matching transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 5210;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: XOR over data and parity bit must be 0, so a 1 here is an error.
  function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                           input logic                      par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value
// so idle-high lines do not look like an edge after reset.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver, 8E1 frames (start, 8 data LSB first, even parity, stop).
// Holds the last byte with valid/error flags until the MMIO side acknowledges it.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      rx_ack,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  uart_state_e               state_reg, state_next;
  logic [CW-1:0]             cnt_reg;
  logic [BW-1:0]             bit_idx_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      parity_bit_reg;
  logic                      rx_s;
  logic                      rx_prev_reg;

  logic [UART_DATA_BITS-1:0] rx_data_reg;
  logic                      rx_valid_reg;
  logic                      parity_err_reg;
  logic                      frame_err_reg;
  logic                      overrun_reg;

  logic fall_edge;
  logic half_tick;
  logic full_tick;
  logic busy_c;
  logic cnt_clr;
  logic bit_clr;
  logic sample_data;
  logic sample_parity;
  logic commit;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_reg <= 1'b1;
    end else begin
      rx_prev_reg <= rx_s;
    end
  end

  // Only a genuine 1->0 transition starts a frame; a line held low is ignored.
  assign fall_edge = rx_prev_reg & ~rx_s;
  assign half_tick = (cnt_reg == CNT_HALF);
  assign full_tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fall_edge) state_next = ST_START;
      end
      ST_START: begin
        if (half_tick) state_next = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (full_tick && (bit_idx_reg == BIT_LAST)) state_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (full_tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (full_tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c        = (state_reg != ST_IDLE);
    bit_clr       = (state_reg == ST_IDLE);
    sample_data   = (state_reg == ST_DATA) && full_tick;
    sample_parity = (state_reg == ST_PARITY) && full_tick;
    commit        = (state_reg == ST_STOP) && full_tick;
    // Restart the baud count on every state entry and between data bits.
    cnt_clr       = (state_next != state_reg) || sample_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (busy_c) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
    end else begin
      if (bit_clr) begin
        bit_idx_reg <= '0;
      end else if (sample_data) begin
        bit_idx_reg <= bit_idx_reg + BW'(1);
      end
      if (sample_data) begin
        shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
      end
      if (sample_parity) begin
        parity_bit_reg <= rx_s;
      end
    end
  end

  // A commit always wins over a same-cycle ack; newest byte overwrites the old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (commit) begin
      rx_data_reg    <= shift_reg;
      rx_valid_reg   <= 1'b1;
      parity_err_reg <= even_parity_err(shift_reg, parity_bit_reg);
      frame_err_reg  <= ~rx_s;
      overrun_reg    <= rx_ack ? 1'b0 : (overrun_reg | rx_valid_reg);
    end else if (rx_ack && rx_valid_reg) begin
      rx_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign busy       = busy_c;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity with a 16-cycle bit time.
module tb_uart_rx_parity;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total_cnt;
  int pass_cnt;

  uart_rx_parity #(.CLKS_PER_BIT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: got %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [7:0] d, input logic v,
                           input logic pe, input logic fe, input logic ov, input logic b);
    chk({tag, ".rx_data"}, rx_data, d);
    chk({tag, ".flags"}, {3'b0, rx_valid, parity_err, frame_err, overrun, busy},
        {3'b0, v, pe, fe, ov, b});
  endtask

  // Bit i is driven for 16 cycles starting at negedge 16*i.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rx = bits[i];
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_flags("reset", 8'h00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0x01 good parity; commit lands 171 rising edges after the start bit.
    fork
      send_frame(8'h01, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (170) @(posedge clk);
        #1;
        chk_flags("t1_pre_commit", 8'h00, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk_flags("t1_commit", 8'h01, 1, 0, 0, 0, 0);
      end
    join
    pulse_ack();
    chk_flags("t1_ack", 8'h01, 0, 0, 0, 0, 0);

    // 2: 0x03 with wrong parity
    send_frame(8'h03, 1'b1, 1'b1);
    chk_flags("t2_perr", 8'h03, 1, 1, 0, 0, 0);
    pulse_ack();
    chk_flags("t2_ack", 8'h03, 0, 0, 0, 0, 0);

    // 3: framing error, then line held low must not start another frame
    send_frame(8'h10, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk_flags("t3_ferr_hold", 8'h10, 1, 0, 1, 0, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h02, 1'b1, 1'b1);
    chk_flags("t3_next", 8'h02, 1, 0, 0, 1, 0);
    pulse_ack();
    chk_flags("t3_ack", 8'h02, 0, 0, 0, 0, 0);

    // 4: 4-cycle glitch is rejected at the half-bit check
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_busy_start", {7'b0, busy}, 8'h01);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_busy_before_check", {7'b0, busy}, 8'h01);
    @(negedge clk);
    chk("t4_busy_after_check", {7'b0, busy}, 8'h00);
    repeat (40) @(negedge clk);
    chk_flags("t4_no_commit", 8'h02, 0, 0, 0, 0, 0);

    // 5: back-to-back without ack -> overrun
    send_frame(8'h0A, 1'b0, 1'b1);
    send_frame(8'h0B, 1'b1, 1'b1);
    chk_flags("t5_overrun", 8'h0B, 1, 0, 0, 1, 0);
    pulse_ack();
    chk_flags("t5_ack", 8'h0B, 0, 0, 0, 0, 0);

    // 5b: ack coincides with the commit of the second byte
    send_frame(8'h0A, 1'b0, 1'b1);
    fork
      send_frame(8'h0B, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (170) @(posedge clk);
        #1;
        chk_flags("t5b_pre_commit", 8'h0A, 1, 0, 0, 0, 1);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk_flags("t5b_ack_on_commit", 8'h0B, 1, 0, 0, 0, 0);
      end
    join

    // 6: reset during data bit 3 of 0x05 clears everything immediately
    fork
      send_frame(8'h05, 1'b0, 1'b1);
      begin
        @(negedge clk);
        repeat (72) @(negedge clk);
        chk_flags("t6_pre_reset", 8'h0B, 1, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk_flags("t6_in_reset", 8'h00, 0, 0, 0, 0, 0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_flags("t6_after_release", 8'h00, 0, 0, 0, 0, 0);
    send_frame(8'h0F, 1'b0, 1'b1);
    chk_flags("t6_next", 8'h0F, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
